// File: rtl/fsbm_pkg.sv
// Shared types and helpers for the SAD best-match search and its raster counter.
// Also used by the pixel feeder that drives the PE array.
package fsbm_pkg;

    localparam int SAD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsbm_raster_cnt.sv
// Column/row raster counter over an NX x NY window.
// Supports clear, advance and a last-position flag.
import fsbm_pkg::*;

module fsbm_raster_cnt #(
    parameter int NX = 13,
    parameter int NY = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  adv_i,
    output logic [cnt_w(NX)-1:0]  col_o,
    output logic [cnt_w(NY)-1:0]  row_o,
    output logic                  last_o
);

    localparam int XW = cnt_w(NX);
    localparam int YW = cnt_w(NY);
    localparam logic [XW-1:0] XMAX = XW'(NX - 1);
    localparam logic [YW-1:0] YMAX = YW'(NY - 1);

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i) begin
            if (col_q == XMAX) begin
                col_d = '0;
                row_d = (row_q == YMAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == XMAX) && (row_q == YMAX);

endmodule

// File: rtl/sad_best_match_select.sv
// Tracks the minimum SAD over a raster search window and reports its motion vector.
// Define SAD_EARLY_TERM_EN to end the search on the first zero SAD.
import fsbm_pkg::*;

module sad_best_match_select #(
    parameter int NX   = 13,
    parameter int NY   = 13,
    parameter int MV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mv_x,
    output logic [MV_W-1:0]  best_mv_y
);

    localparam int XW = cnt_w(NX);
    localparam int YW = cnt_w(NY);
    localparam logic [MV_W-1:0] CX = MV_W'((NX - 1) / 2);
    localparam logic [MV_W-1:0] CY = MV_W'((NY - 1) / 2);

    state_t state_q, state_d;
    logic [SAD_W-1:0] run_min_q, run_min_d;
    logic [XW-1:0]    run_col_q, run_col_d;
    logic [YW-1:0]    run_row_q, run_row_d;
    logic [SAD_W-1:0] best_sad_q;
    logic [MV_W-1:0]  best_mv_x_q, best_mv_y_q;

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          last;
    logic          clr, acc, fin, zero_hit;

    assign clr = (state_q == IDLE) && start;
    assign acc = (state_q == SCAN) && sad_valid;

`ifdef SAD_EARLY_TERM_EN
    assign zero_hit = (sad == '0);
`else
    assign zero_hit = 1'b0;
`endif

    assign fin = acc && (last || zero_hit);

    fsbm_raster_cnt #(
        .NX(NX),
        .NY(NY)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .adv_i  (acc),
        .col_o  (col),
        .row_o  (row),
        .last_o (last)
    );

    always_comb begin
        state_d   = state_q;
        run_min_d = run_min_q;
        run_col_d = run_col_q;
        run_row_d = run_row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    run_min_d = '1;
                    run_col_d = '0;
                    run_row_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                // Strict compare: ties keep the earlier raster candidate.
                if (acc && (sad < run_min_q)) begin
                    run_min_d = sad;
                    run_col_d = col;
                    run_row_d = row;
                end
                if (fin) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            run_min_q <= '1;
            run_col_q <= '0;
            run_row_q <= '0;
        end else begin
            state_q   <= state_d;
            run_min_q <= run_min_d;
            run_col_q <= run_col_d;
            run_row_q <= run_row_d;
        end
    end

    // Results load on the final accept so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            best_sad_q  <= '1;
            best_mv_x_q <= '0;
            best_mv_y_q <= '0;
        end else if (fin) begin
            best_sad_q  <= run_min_d;
            best_mv_x_q <= MV_W'(run_col_d) - CX;
            best_mv_y_q <= MV_W'(run_row_d) - CY;
        end
    end

    assign busy      = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign best_sad  = best_sad_q;
    assign best_mv_x = best_mv_x_q;
    assign best_mv_y = best_mv_y_q;

endmodule

// File: tb/tb_sad_best_match_select.sv
// Scoreboard bench for sad_best_match_select: random and directed searches
// checked against a plain-arithmetic minimum-search model.
module tb_sad_best_match_select;

    localparam int N = 169;

    typedef struct {
        int sad;
        int mvx;
        int mvy;
        int cyc;
        int n;
    } exp_t;

    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0;
    logic        sad_valid = 0;
    logic [11:0] sad = '0;
    logic        busy, done;
    logic [11:0] best_sad;
    logic [4:0]  best_mv_x, best_mv_y;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   sads[N];
    exp_t sb[$];

    sad_best_match_select dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sad_valid (sad_valid),
        .sad       (sad),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_mv_x (best_mv_x),
        .best_mv_y (best_mv_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: first strict minimum in raster order, optional stop on zero.
    function automatic exp_t model();
        exp_t e;
        int best = 4095;
        int idx = 0;
        e.n = N;
        for (int i = 0; i < N; i++) begin
            if (sads[i] < best) begin
                best = sads[i];
                idx = i;
            end
`ifdef SAD_EARLY_TERM_EN
            if (sads[i] == 0) begin
                e.n = i + 1;
                break;
            end
`endif
        end
        e.sad = best;
        e.mvx = (idx % 13) - 6;
        e.mvy = (idx / 13) - 6;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done must match the oldest expected result.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("best_sad", int'(best_sad), e.sad);
                chk("best_mv_x", int'($signed(best_mv_x)), e.mvx);
                chk("best_mv_y", int'($signed(best_mv_y)), e.mvy);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input int gap, input bit mid_start,
                            input int abort_at);
        exp_t e;
        e = model();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < e.n; i++) begin
            if (abort_at >= 0 && i == abort_at) begin
                sad_valid = 0;
                rst = 0;
                tick();
                rst = 1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_best_sad", int'(best_sad), 4095);
                repeat (N + 5) tick();
                return;
            end
            sad_valid = 1;
            sad = 12'(sads[i]);
            if (mid_start && i == 50) start = 1;
            if (i == e.n - 1) begin
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
            tick();
            start = 0;
            sad_valid = 0;
            if (i == 10) chk("busy_in_scan", int'(busy), 1);
            repeat (gap) tick();
        end
        // Trailing valids land in DONE/IDLE and must be ignored.
        for (int k = 0; k < 4; k++) begin
            sad_valid = 1;
            sad = '0;
            tick();
        end
        sad_valid = 0;
        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) sads[i] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < N; i++) sads[i] = int'($urandom_range(hi, lo));
    endtask

    initial begin
        #5_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (3) tick();
        rst = 1;
        tick();
        chk("rst_best_sad", int'(best_sad), 4095);
        chk("rst_mv_x", int'(best_mv_x), 0);
        chk("rst_mv_y", int'(best_mv_y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        for (int k = 0; k < 3; k++) begin
            sad_valid = 1;
            sad = 12'(k);
            tick();
        end
        sad_valid = 0;
        tick();
        chk("idle_best_sad", int'(best_sad), 4095);
        chk("idle_mv_x", int'(best_mv_x), 0);
        chk("idle_busy", int'(busy), 0);

        fill(100);
        sads[35] = 7;
        run_scan(0, 0, -1);

        fill(200);
        sads[20] = 5;
        sads[150] = 5;
        run_scan(0, 0, -1);

        fill(100);
        sads[35] = 7;
        run_scan(2, 1, -1);

        fill_rand(1, 4095);
        run_scan(0, 0, 80);
        fill_rand(1, 4095);
        run_scan(0, 0, -1);

        fill_rand(1, 4095);
        sads[30] = 0;
        run_scan(0, 0, -1);

        for (int t = 0; t < 4; t++) begin
            fill_rand(1, 40);
            run_scan(t % 3, 0, -1);
        end
        fill_rand(0, 30);
        run_scan(1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
